// File: rtl/instruction_encoder_pkg.sv
// ----------------------------------------------------------------------------
// instruction_encoder_pkg
// Purpose : shared types for the RV32I instruction encoder (program loader).
//           Holds the decoded-field types the encoder consumes, the
//           instruction format enum, opcode constants, the NOP word and the
//           registered field bundle / FSM state types.
// Ports   : none (package).
// Config  : ENCODER_IMM_RANGE_CHECK_EN is consumed by instruction_packer.
// ----------------------------------------------------------------------------
package instruction_encoder_pkg;

    typedef logic [31:0] t_data;
    typedef logic [4:0]  t_register_index;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND, ALU_SLL, ALU_SRL, ALU_SRA
    } t_alu_operation;

    typedef enum logic [1:0] {
        BRANCH_NONE, BRANCH_NE, BRANCH_JUMP
    } t_branch_condition;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_S, FMT_B, FMT_J
    } t_instr_format;

    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;

    localparam t_data INSTR_NOP = 32'h0000_0013;

    // Decoded fields captured on acceptance.
    typedef struct packed {
        t_alu_operation    alu_operation;
        t_branch_condition branch_condition;
        logic              memory_write_enable;
        logic              use_immediate;
        t_register_index   destination_register;
        t_register_index   source_register1;
        t_register_index   source_register2;
        t_data             immediate;
    } t_bundle;

    typedef enum logic [1:0] {
        ST_IDLE, ST_ENCODE, ST_WRITE, ST_DONE
    } t_enc_state;

endpackage

// File: rtl/instruction_encoder_packer.sv
// ----------------------------------------------------------------------------
// instruction_packer
// Purpose : purely combinational packing of a decoded field bundle into an
//           RV32I instruction word. Unsupported op/class combinations (and,
//           when ENCODER_IMM_RANGE_CHECK_EN is defined, immediates that do not
//           fit their format) produce INSTR_NOP and raise o_unsupported.
// Ports   : i_bundle       registered field bundle
//           o_word         encoded instruction word
//           o_unsupported  word was replaced by NOP
// Config  : ENCODER_IMM_RANGE_CHECK_EN - enable immediate range checking;
//           otherwise immediates are truncated to the format's bits.
// ----------------------------------------------------------------------------
module instruction_packer
    import instruction_encoder_pkg::*;
(
    input  t_bundle i_bundle,
    output t_data   o_word,
    output logic    o_unsupported
);

    t_instr_format w_fmt;
    logic [6:0]    w_opcode;
    logic [2:0]    w_funct3;
    logic [6:0]    w_funct7;
    logic          w_shift;
    logic          w_bad;
    logic          w_range_ok;
    t_data         w_imm;
    t_data         w_raw;

    assign w_imm = i_bundle.immediate;

    // Upper immediate bits only matter for range checking.
    logic w_unused_imm;
    assign w_unused_imm = ^w_imm[31:21];

    // Class selection, in priority order.
    always_comb begin
        w_fmt    = FMT_R;
        w_opcode = OPCODE_OP;
        w_funct3 = 3'b000;
        w_funct7 = 7'b0000000;
        w_shift  = 1'b0;
        w_bad    = 1'b0;
        if (i_bundle.branch_condition == BRANCH_JUMP) begin
            w_fmt    = FMT_J;
            w_opcode = OPCODE_JAL;
        end else if (i_bundle.branch_condition == BRANCH_NE) begin
            w_fmt    = FMT_B;
            w_opcode = OPCODE_BRANCH;
            w_funct3 = 3'b001;
        end else if (i_bundle.memory_write_enable) begin
            w_fmt    = FMT_S;
            w_opcode = OPCODE_STORE;
            w_funct3 = 3'b010;
        end else if (i_bundle.use_immediate) begin
            w_fmt    = FMT_I;
            w_opcode = OPCODE_OP_IMM;
            case (i_bundle.alu_operation)
                ALU_ADD: w_funct3 = 3'b000;
                ALU_XOR: w_funct3 = 3'b100;
                ALU_OR:  w_funct3 = 3'b110;
                ALU_AND: w_funct3 = 3'b111;
                ALU_SLL: begin w_funct3 = 3'b001; w_shift = 1'b1; end
                ALU_SRL: begin w_funct3 = 3'b101; w_shift = 1'b1; end
                ALU_SRA: begin w_funct3 = 3'b101; w_shift = 1'b1; w_funct7 = 7'b0100000; end
                default: w_bad = 1'b1;
            endcase
        end else begin
            case (i_bundle.alu_operation)
                ALU_ADD: w_funct7 = 7'b0000000;
                ALU_SUB: w_funct7 = 7'b0100000;
                default: w_bad = 1'b1;
            endcase
        end
    end

`ifdef ENCODER_IMM_RANGE_CHECK_EN
    // Signed fit: all bits above the format's sign bit equal the sign bit.
    always_comb begin
        w_range_ok = 1'b1;
        case (w_fmt)
            FMT_I: w_range_ok = w_shift ? (w_imm[31:5] == '0)
                                        : ((w_imm[31:11] == '0) || (w_imm[31:11] == '1));
            FMT_S: w_range_ok = (w_imm[31:11] == '0) || (w_imm[31:11] == '1);
            FMT_B: w_range_ok = ((w_imm[31:12] == '0) || (w_imm[31:12] == '1)) && !w_imm[0];
            FMT_J: w_range_ok = ((w_imm[31:20] == '0) || (w_imm[31:20] == '1)) && !w_imm[0];
            default: w_range_ok = 1'b1;
        endcase
    end
`else
    assign w_range_ok = 1'b1;
`endif

    always_comb begin
        w_raw = INSTR_NOP;
        case (w_fmt)
            FMT_R: w_raw = {w_funct7, i_bundle.source_register2, i_bundle.source_register1,
                            w_funct3, i_bundle.destination_register, w_opcode};
            // Shifts carry funct7 in imm[11:5] and shamt in imm[4:0].
            FMT_I: w_raw = w_shift
                         ? {w_funct7, w_imm[4:0], i_bundle.source_register1,
                            w_funct3, i_bundle.destination_register, w_opcode}
                         : {w_imm[11:0], i_bundle.source_register1,
                            w_funct3, i_bundle.destination_register, w_opcode};
            FMT_S: w_raw = {w_imm[11:5], i_bundle.source_register2, i_bundle.source_register1,
                            w_funct3, w_imm[4:0], w_opcode};
            FMT_B: w_raw = {w_imm[12], w_imm[10:5], i_bundle.source_register2,
                            i_bundle.source_register1, w_funct3, w_imm[4:1], w_imm[11], w_opcode};
            FMT_J: w_raw = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12],
                            i_bundle.destination_register, w_opcode};
            default: w_raw = INSTR_NOP;
        endcase
    end

    assign o_unsupported = w_bad || !w_range_ok;
    assign o_word        = o_unsupported ? INSTR_NOP : w_raw;

endmodule

// File: rtl/instruction_encoder.sv
// ----------------------------------------------------------------------------
// instruction_encoder
// Purpose : program loader. Accepts decoded field bundles over valid/ready,
//           packs each into an RV32I word (instruction_packer) and writes it
//           to instruction memory at BASE_ADDRESS + 4*count. One word per
//           three cycles: IDLE (accept) -> ENCODE -> WRITE (strobe).
// Ports   : i_clk, i_reset_n (sync, active low)
//           i_valid/o_ready/i_last       bundle handshake
//           i_alu_operation .. i_immediate decoded fields
//           i_restart                    leave DONE, clear count and error
//           o_memory_write_enable/address/write_data  memory write port
//           o_count                      words written (saturates at DEPTH)
//           o_done, o_error              program complete / sticky error
// Config  : ENCODER_IMM_RANGE_CHECK_EN (see instruction_packer).
// ----------------------------------------------------------------------------
module instruction_encoder
    import instruction_encoder_pkg::*;
#(
    parameter t_data BASE_ADDRESS = 32'h0000_0000,
    parameter int    DEPTH        = 256
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic                     i_last,
    input  t_alu_operation           i_alu_operation,
    input  t_branch_condition        i_branch_condition,
    input  logic                     i_memory_write_enable,
    input  logic                     i_use_immediate,
    input  t_register_index          i_destination_register,
    input  t_register_index          i_source_register1,
    input  t_register_index          i_source_register2,
    input  t_data                    i_immediate,
    input  logic                     i_restart,
    output logic                     o_memory_write_enable,
    output t_data                    o_memory_address,
    output t_data                    o_memory_write_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_done,
    output logic                     o_error
);

    localparam int CW = $clog2(DEPTH) + 1;

    t_enc_state    r_state, w_next;
    t_bundle       r_fields;
    logic          r_last;
    t_data         r_word;
    logic [CW-1:0] r_count;
    logic          r_error;

    t_data         w_word;
    logic          w_unsupported;
    logic          w_accept;
    logic          w_full;

    instruction_packer u_packer (
        .i_bundle      (r_fields),
        .o_word        (w_word),
        .o_unsupported (w_unsupported)
    );

    assign w_full = (r_count == CW'(DEPTH));

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) r_state <= ST_IDLE;
        else            r_state <= w_next;
    end

    always_comb begin
        w_next                = r_state;
        o_ready               = 1'b0;
        o_memory_write_enable = 1'b0;
        o_done                = 1'b0;
        w_accept              = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    w_accept = 1'b1;
                    // A bundle arriving with memory full is dropped and aborts the program.
                    w_next   = w_full ? ST_DONE : ST_ENCODE;
                end
            end
            ST_ENCODE: w_next = ST_WRITE;
            ST_WRITE: begin
                o_memory_write_enable = 1'b1;
                w_next = r_last ? ST_DONE : ST_IDLE;
            end
            ST_DONE: begin
                o_done = 1'b1;
                if (i_restart) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_fields <= '0;
            r_last   <= 1'b0;
            r_word   <= '0;
            r_count  <= '0;
            r_error  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_fields.alu_operation        <= i_alu_operation;
                r_fields.branch_condition     <= i_branch_condition;
                r_fields.memory_write_enable  <= i_memory_write_enable;
                r_fields.use_immediate        <= i_use_immediate;
                r_fields.destination_register <= i_destination_register;
                r_fields.source_register1     <= i_source_register1;
                r_fields.source_register2     <= i_source_register2;
                r_fields.immediate            <= i_immediate;
                r_last                        <= i_last;
                if (w_full) r_error <= 1'b1;
            end
            if (r_state == ST_ENCODE) begin
                r_word <= w_word;
                if (w_unsupported) r_error <= 1'b1;
            end
            if (r_state == ST_WRITE && !w_full) r_count <= r_count + CW'(1);
            if (r_state == ST_DONE && i_restart) begin
                r_count <= '0;
                r_error <= 1'b0;
            end
        end
    end

    // Address/data are driven only during the strobe so idle outputs read 0.
    assign o_memory_address    = o_memory_write_enable ? (BASE_ADDRESS + (32'(r_count) << 2)) : '0;
    assign o_memory_write_data = o_memory_write_enable ? r_word : '0;
    assign o_count             = r_count;
    assign o_error             = r_error;

endmodule

// File: tb/tb_instruction_encoder.sv
module tb_instruction_encoder;
    import instruction_encoder_pkg::*;

    localparam t_data BASE2 = 32'h0000_0100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n = 1'b0;
    logic              v1 = 1'b0, v2 = 1'b0, f_last = 1'b0, rs1_req = 1'b0, rs2_req = 1'b0;
    t_alu_operation    f_op = ALU_ADD;
    t_branch_condition f_br = BRANCH_NONE;
    logic              f_we = 1'b0, f_ui = 1'b0;
    t_register_index   f_rd = '0, f_r1 = '0, f_r2 = '0;
    t_data             f_imm = '0;

    logic        rdy1, we1, done1, err1, rdy2, we2, done2, err2;
    t_data       addr1, data1, addr2, data2;
    logic [8:0]  cnt1;
    logic [1:0]  cnt2;

    instruction_encoder #(.BASE_ADDRESS(32'h0), .DEPTH(256)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_valid(v1), .o_ready(rdy1), .i_last(f_last),
        .i_alu_operation(f_op), .i_branch_condition(f_br), .i_memory_write_enable(f_we),
        .i_use_immediate(f_ui), .i_destination_register(f_rd), .i_source_register1(f_r1),
        .i_source_register2(f_r2), .i_immediate(f_imm), .i_restart(rs1_req),
        .o_memory_write_enable(we1), .o_memory_address(addr1), .o_memory_write_data(data1),
        .o_count(cnt1), .o_done(done1), .o_error(err1));

    instruction_encoder #(.BASE_ADDRESS(BASE2), .DEPTH(2)) dut2 (
        .i_clk(clk), .i_reset_n(rst_n), .i_valid(v2), .o_ready(rdy2), .i_last(f_last),
        .i_alu_operation(f_op), .i_branch_condition(f_br), .i_memory_write_enable(f_we),
        .i_use_immediate(f_ui), .i_destination_register(f_rd), .i_source_register1(f_r1),
        .i_source_register2(f_r2), .i_immediate(f_imm), .i_restart(rs2_req),
        .o_memory_write_enable(we2), .o_memory_address(addr2), .o_memory_write_data(data2),
        .o_count(cnt2), .o_done(done2), .o_error(err2));

    int checks = 0;
    int errors = 0;

    typedef struct packed { t_data addr; t_data data; } t_wr;
    t_wr sb1[$];
    t_wr sb2[$];
    int  n1 = 0, n2 = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, sample 1 time unit after the edge, score any strobes.
    task automatic tick();
        t_wr e;
        @(posedge clk);
        #1;
        if (we1) begin
            if (sb1.size() == 0) check("dut1_unexpected_strobe", 32'(we1), 32'd0);
            else begin
                e = sb1.pop_front();
                check("dut1_addr", addr1, e.addr);
                check("dut1_data", data1, e.data);
            end
        end
        if (we2) begin
            if (sb2.size() == 0) check("dut2_unexpected_strobe", 32'(we2), 32'd0);
            else begin
                e = sb2.pop_front();
                check("dut2_addr", addr2, e.addr);
                check("dut2_data", data2, e.data);
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        n1 = 0;
        n2 = 0;
    endtask

    task automatic send(input int d, input t_alu_operation op, input t_branch_condition br,
                        input logic we, input logic ui, input t_register_index rd,
                        input t_register_index r1, input t_register_index r2, input t_data imm,
                        input logic lst, input t_data exp, input logic writes);
        logic ok;
        f_op = op; f_br = br; f_we = we; f_ui = ui;
        f_rd = rd; f_r1 = r1; f_r2 = r2; f_imm = imm; f_last = lst;
        if (writes) begin
            if (d == 0) begin sb1.push_back('{32'(4 * n1), exp}); n1++; end
            else        begin sb2.push_back('{BASE2 + 32'(4 * n2), exp}); n2++; end
        end
        if (d == 0) v1 = 1'b1; else v2 = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if ((d == 0) ? rdy1 : rdy2) ok = 1'b1;
            tick();
        end
        v1 = 1'b0;
        v2 = 1'b0;
        f_last = 1'b0;
        check("accept_within_budget", 32'(ok), 32'd1);
        if (writes) begin
            check("encode_cycle_no_strobe", 32'((d == 0) ? we1 : we2), 32'd0);
            tick();
            check("strobe_latency", 32'((d == 0) ? we1 : we2), 32'd1);
            tick();
        end
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_ready", 32'(rdy1), 32'd1);
        check("rst_strobe", 32'(we1), 32'd0);
        check("rst_addr", addr1, 32'd0);
        check("rst_data", data1, 32'd0);
        check("rst_count", 32'(cnt1), 32'd0);
        check("rst_done", 32'(done1), 32'd0);
        check("rst_error", 32'(err1), 32'd0);

        // 1: addi x1,x0,5
        send(0, ALU_ADD, BRANCH_NONE, 1'b0, 1'b1, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 32'h0050_0093, 1'b1);
        check("t1_count", 32'(cnt1), 32'd1);

        // 2: srai x5,x6,3 ; sw x2,8(x1) ; restart outside DONE ignored
        do_reset();
        send(0, ALU_SRA, BRANCH_NONE, 1'b0, 1'b1, 5'd5, 5'd6, 5'd0, 32'd3, 1'b0, 32'h4033_5293, 1'b1);
        send(0, ALU_ADD, BRANCH_NONE, 1'b1, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0, 32'h0020_A423, 1'b1);
        rs1_req = 1'b1; tick(); rs1_req = 1'b0;
        check("t2_count_after_idle_restart", 32'(cnt1), 32'd2);
        check("t2_ready_after_idle_restart", 32'(rdy1), 32'd1);

        // 3: bne x1,x2,-4 ; jal x1,8 (last) ; restart
        do_reset();
        send(0, ALU_ADD, BRANCH_NE, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, -32'sd4, 1'b0, 32'hFE20_9EE3, 1'b1);
        send(0, ALU_ADD, BRANCH_JUMP, 1'b0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8, 1'b1, 32'h0080_00EF, 1'b1);
        check("t3_done", 32'(done1), 32'd1);
        check("t3_ready_in_done", 32'(rdy1), 32'd0);
        check("t3_count", 32'(cnt1), 32'd2);
        rs1_req = 1'b1; tick(); rs1_req = 1'b0;
        check("t3_count_after_restart", 32'(cnt1), 32'd0);
        check("t3_done_after_restart", 32'(done1), 32'd0);
        check("t3_ready_after_restart", 32'(rdy1), 32'd1);

        // 4: DEPTH=2 overflow on third bundle
        do_reset();
        send(1, ALU_ADD, BRANCH_NONE, 1'b0, 1'b1, 5'd1, 5'd0, 5'd0, 32'd1, 1'b0, 32'h0010_0093, 1'b1);
        send(1, ALU_ADD, BRANCH_NONE, 1'b0, 1'b1, 5'd2, 5'd0, 5'd0, 32'd2, 1'b0, 32'h0020_0113, 1'b1);
        send(1, ALU_ADD, BRANCH_NONE, 1'b0, 1'b1, 5'd3, 5'd0, 5'd0, 32'd3, 1'b0, 32'h0030_0193, 1'b0);
        check("t4_done", 32'(done2), 32'd1);
        check("t4_error", 32'(err2), 32'd1);
        tick(); tick();
        check("t4_count_saturated", 32'(cnt2), 32'd2);
        rs2_req = 1'b1; tick(); rs2_req = 1'b0;
        check("t4_error_cleared", 32'(err2), 32'd0);
        check("t4_count_cleared", 32'(cnt2), 32'd0);

        // 5: ori, sub (supported), then OP XOR (unsupported -> NOP)
        do_reset();
        send(0, ALU_OR, BRANCH_NONE, 1'b0, 1'b1, 5'd3, 5'd4, 5'd0, 32'hFFFF_FFFF, 1'b0, 32'hFFF2_6193, 1'b1);
        send(0, ALU_SUB, BRANCH_NONE, 1'b0, 1'b0, 5'd7, 5'd8, 5'd9, 32'd0, 1'b0, 32'h4094_03B3, 1'b1);
        check("t5_error_before", 32'(err1), 32'd0);
        send(0, ALU_XOR, BRANCH_NONE, 1'b0, 1'b0, 5'd7, 5'd8, 5'd9, 32'd0, 1'b0, INSTR_NOP, 1'b1);
        check("t5_error_after", 32'(err1), 32'd1);
        check("t5_count", 32'(cnt1), 32'd3);

        // 6: reset during ENCODE aborts without a strobe
        do_reset();
        f_op = ALU_ADD; f_br = BRANCH_NONE; f_we = 1'b0; f_ui = 1'b1;
        f_rd = 5'd1; f_r1 = 5'd0; f_imm = 32'd7;
        v1 = 1'b1;
        tick();
        v1 = 1'b0;
        check("t6_in_encode_ready", 32'(rdy1), 32'd0);
        rst_n = 1'b0;
        tick();
        check("t6_no_strobe", 32'(we1), 32'd0);
        check("t6_ready", 32'(rdy1), 32'd1);
        rst_n = 1'b1;
        n1 = 0;
        tick(); tick(); tick();
        check("t6_count", 32'(cnt1), 32'd0);

        // 6b: addi x1,x0,2048
        do_reset();
`ifdef ENCODER_IMM_RANGE_CHECK_EN
        send(0, ALU_ADD, BRANCH_NONE, 1'b0, 1'b1, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0, INSTR_NOP, 1'b1);
        check("t6b_error", 32'(err1), 32'd1);
`else
        send(0, ALU_ADD, BRANCH_NONE, 1'b0, 1'b1, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0, 32'h8000_0093, 1'b1);
        check("t6b_error", 32'(err1), 32'd0);
`endif

        tick();
        check("sb1_drained", 32'(sb1.size()), 32'd0);
        check("sb2_drained", 32'(sb2.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
